// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite datapath: default sizes, bus widths,
// the queued-command record layout and the transparent colour key.
package sprite_pkg;

   localparam int DEF_NUM_SPRITES = 8;
   localparam int DEF_IDX_W       = 3;
   localparam int X_W             = 10;
   localparam int Y_W             = 9;

   // RGB332 colour key treated as transparent by the sprite pixel path
   localparam logic [7:0] TRANS = 8'hE3;

   // Field order matches the packed FIFO word: {idx, att, x, y, vis}
   typedef struct packed {
      logic [DEF_IDX_W-1:0] idx;
      logic                 att;
      logic [X_W-1:0]       x;
      logic [Y_W-1:0]       y;
      logic                 vis;
   } sprite_cmd_t;

   function automatic int cmd_width(input int idx_w);
      return idx_w + 1 + X_W + Y_W + 1;
   endfunction

endpackage

// File: rtl/sprite_loader_fifo.sv
// Synchronous command FIFO with occupancy count; head word is presented
// combinationally on rdata while not empty.
module cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (count_r == (AW+1)'(0));
   assign full      = (count_r == (AW+1)'(DEPTH));
   assign do_pop_s  = pop && !empty;
   // a full FIFO can still take a word when the head leaves in the same cycle
   assign do_push_s = push && (!full || do_pop_s);
   assign rdata     = mem_r[rd_ptr_r];
   assign count     = count_r;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= (AW+1)'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // storage array, written at the tail
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/sprite_loader.sv
// Buffers sprite position/attribute updates and replays them onto the shared
// sprite load bus only while vblank is high, one strobe per three cycles.
module sprite_loader
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = DEF_NUM_SPRITES,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [IDX_W-1:0]              cmd_idx,
   input  logic                          cmd_att,
   input  logic [X_W-1:0]                cmd_x,
   input  logic [Y_W-1:0]                cmd_y,
   input  logic                          cmd_vis,
   input  logic                          vblank,
   output logic [NUM_SPRITES-1:0]        load_pos,
   output logic [NUM_SPRITES-1:0]        load_att,
   output logic [X_W-1:0]                x,
   output logic [Y_W-1:0]                y,
   output logic                          visible,
   output logic [$clog2(FIFO_DEPTH):0]   pending,
   output logic                          bad_idx
);

   localparam int CMD_W = cmd_width(IDX_W);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STROBE = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;

   logic [1:0]             state_r;
   logic [1:0]             state_nx_s;
   logic [CMD_W-1:0]       head_s;
   logic [CMD_W-1:0]       wdata_s;
   logic                   full_s;
   logic                   empty_s;
   logic                   push_s;
   logic                   pop_s;
   logic [IDX_W-1:0]       head_idx_s;
   logic                   head_att_s;
   logic [X_W-1:0]         head_x_s;
   logic [Y_W-1:0]         head_y_s;
   logic                   head_vis_s;
   logic                   in_range_s;
   logic [NUM_SPRITES-1:0] onehot_s;
   logic [NUM_SPRITES-1:0] load_pos_r;
   logic [NUM_SPRITES-1:0] load_att_r;
   logic [X_W-1:0]         x_r;
   logic [Y_W-1:0]         y_r;
   logic                   visible_r;
   logic                   bad_idx_r;

   assign cmd_ready = !full_s && !rst;
   assign push_s    = cmd_valid && cmd_ready;
   assign wdata_s   = {cmd_idx, cmd_att, cmd_x, cmd_y, cmd_vis};
   assign pop_s     = (state_r == ST_IDLE) && vblank && !empty_s;

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (wdata_s),
      .rdata (head_s),
      .full  (full_s),
      .empty (empty_s),
      .count (pending)
   );

   assign head_idx_s = head_s[CMD_W-1 -: IDX_W];
   assign head_att_s = head_s[X_W+Y_W+1];
   assign head_x_s   = head_s[Y_W+1 +: X_W];
   assign head_y_s   = head_s[1 +: Y_W];
   assign head_vis_s = head_s[0];
   assign in_range_s = (int'(head_idx_s) < NUM_SPRITES);

   // decode head index; out-of-range indices decode to all zeros
   always_comb begin
      onehot_s = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         onehot_s[i] = (int'(head_idx_s) == i);
      end
   end

   // IDLE -> STROBE -> GAP -> IDLE, leaving IDLE only on a pop
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pop_s) begin
               state_nx_s = ST_STROBE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_STROBE: state_nx_s = ST_GAP;
         ST_GAP:    state_nx_s = ST_IDLE;
         default:   state_nx_s = ST_IDLE;
      endcase
   end

   // state, strobe and shared-bus registers; the bus only moves on a pop
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         load_pos_r <= '0;
         load_att_r <= '0;
         x_r        <= {X_W{1'b0}};
         y_r        <= {Y_W{1'b0}};
         visible_r  <= 1'b0;
         bad_idx_r  <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         load_pos_r <= (pop_s && !head_att_s) ? onehot_s : '0;
         load_att_r <= (pop_s &&  head_att_s) ? onehot_s : '0;
         bad_idx_r  <= bad_idx_r || (pop_s && !in_range_s);
         if (pop_s) begin
            x_r       <= head_x_s;
            y_r       <= head_y_s;
            visible_r <= head_vis_s;
         end else begin
            x_r       <= x_r;
            y_r       <= y_r;
            visible_r <= visible_r;
         end
      end
   end

   assign load_pos = load_pos_r;
   assign load_att = load_att_r;
   assign x        = x_r;
   assign y        = y_r;
   assign visible  = visible_r;
   assign bad_idx  = bad_idx_r;

endmodule

// File: tb/tb_sprite_loader.sv
// Randomised scoreboard bench for sprite_loader: an 8-sprite instance is
// scoreboarded strobe by strobe, a 6-sprite twin is checked for index range.
module tb_sprite_loader;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [2:0] cmd_idx;
   logic       cmd_att;
   logic [9:0] cmd_x;
   logic [8:0] cmd_y;
   logic       cmd_vis;
   logic       vblank;

   logic       cmd_ready_a, visible_a, bad_a;
   logic [7:0] load_pos_a, load_att_a;
   logic [9:0] x_a;
   logic [8:0] y_a;
   logic [2:0] pending_a;

   logic       cmd_ready_b, visible_b, bad_b;
   logic [5:0] load_pos_b, load_att_b;
   logic [9:0] x_b;
   logic [8:0] y_b;
   logic [2:0] pending_b;

   sprite_loader #(.NUM_SPRITES(8), .IDX_W(3), .FIFO_DEPTH(DEPTH)) dut_a (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
      .cmd_idx(cmd_idx), .cmd_att(cmd_att), .cmd_x(cmd_x), .cmd_y(cmd_y),
      .cmd_vis(cmd_vis), .vblank(vblank), .load_pos(load_pos_a),
      .load_att(load_att_a), .x(x_a), .y(y_a), .visible(visible_a),
      .pending(pending_a), .bad_idx(bad_a)
   );

   sprite_loader #(.NUM_SPRITES(6), .IDX_W(3), .FIFO_DEPTH(DEPTH)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
      .cmd_idx(cmd_idx), .cmd_att(cmd_att), .cmd_x(cmd_x), .cmd_y(cmd_y),
      .cmd_vis(cmd_vis), .vblank(vblank), .load_pos(load_pos_b),
      .load_att(load_att_b), .x(x_b), .y(y_b), .visible(visible_b),
      .pending(pending_b), .bad_idx(bad_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] idx;
      logic       att;
      logic [9:0] x;
      logic [8:0] y;
      logic       vis;
      int         due;
   } rec_t;

   rec_t mq[$];   // reference model of the command queue
   rec_t sb[$];   // expected strobes of dut_a, with the cycle they must appear

   int         checks = 0;
   int         errors = 0;
   int         busy = 0;       // cycles the loader still needs before the next issue
   logic [9:0] ex = 10'd0;
   logic [8:0] ey = 9'd0;
   logic       ev = 1'b0;
   logic       eb_b = 1'b0;
   logic [5:0] epos_b = 6'd0;
   logic [5:0] eatt_b = 6'd0;
   bit         acc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference behaviour for one rising edge, from the inputs now applied.
   task automatic model_edge();
      rec_t h;
      bit   rdy;
      rdy    = !rst && (mq.size() < DEPTH);
      acc    = cmd_valid && rdy;
      epos_b = 6'd0;
      eatt_b = 6'd0;
      if (rst) begin
         mq.delete();
         busy = 0;
         ex   = 10'd0;
         ey   = 9'd0;
         ev   = 1'b0;
         eb_b = 1'b0;
      end else begin
         if (busy == 0 && vblank && mq.size() > 0) begin
            h     = mq.pop_front();
            h.due = cyc + 1;
            sb.push_back(h);
            ex    = h.x;
            ey    = h.y;
            ev    = h.vis;
            busy  = 2;
            if (h.idx < 3'd6) begin
               if (h.att) eatt_b[h.idx] = 1'b1;
               else       epos_b[h.idx] = 1'b1;
            end else begin
               eb_b = 1'b1;
            end
         end else if (busy > 0) begin
            busy--;
         end
         if (acc) begin
            h.idx = cmd_idx; h.att = cmd_att; h.x = cmd_x; h.y = cmd_y;
            h.vis = cmd_vis; h.due = 0;
            mq.push_back(h);
         end
      end
   endtask

   task automatic tick();
      #1;
      chk("cmd_ready_a", cmd_ready_a, !rst && (mq.size() < DEPTH));
      chk("cmd_ready_b", cmd_ready_b, !rst && (mq.size() < DEPTH));
      model_edge();
      @(posedge clk);
      #1;
      chk("pending_a", pending_a, mq.size());
      chk("pending_b", pending_b, mq.size());
      chk("x", x_a, ex);
      chk("y", y_a, ey);
      chk("visible", visible_a, ev);
      chk("bad_idx_a", bad_a, 0);
      chk("bad_idx_b", bad_b, eb_b);
      chk("load_pos_b", load_pos_b, epos_b);
      chk("load_att_b", load_att_b, eatt_b);
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic push_cmd(input logic [2:0] i, input logic a, input logic [9:0] xx,
                           input logic [8:0] yy, input logic v);
      bit done;
      done = 1'b0;
      cmd_valid = 1'b1; cmd_idx = i; cmd_att = a; cmd_x = xx; cmd_y = yy; cmd_vis = v;
      for (int n = 0; n < 64 && !done; n++) begin
         tick();
         done = acc;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL push_timeout actual=not_accepted expected=accepted (cycle %0d)", cyc);
      end
      cmd_valid = 1'b0;
   endtask

   // Scoreboard monitor: every strobe on dut_a must match the next expected record.
   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         if ((load_pos_a | load_att_a) != 8'd0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL strobe_unexpected actual=%0h/%0h expected=none (cycle %0d)",
                        load_pos_a, load_att_a, cyc);
            end else begin
               e = sb.pop_front();
               chk("strobe_cycle", cyc, e.due);
               chk("load_pos", load_pos_a, e.att ? 8'h00 : (8'h01 << e.idx));
               chk("load_att", load_att_a, e.att ? (8'h01 << e.idx) : 8'h00);
               chk("strobe_x", x_a, e.x);
               chk("strobe_y", y_a, e.y);
               chk("strobe_vis", visible_a, e.vis);
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL strobe_missing actual=none expected=idx%0d (cycle %0d)", sb[0].idx, cyc);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_idx = 3'd0; cmd_att = 1'b0;
      cmd_x = 10'd0; cmd_y = 9'd0; cmd_vis = 1'b0; vblank = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(2);

      // single position load inside blanking
      vblank = 1'b1;
      push_cmd(3'd2, 1'b0, 10'h0A0, 9'h050, 1'b0);
      idle(6);

      // commands held while not blanking, then released in order
      vblank = 1'b0;
      push_cmd(3'd1, 1'b0, 10'h011, 9'h021, 1'b0);
      push_cmd(3'd4, 1'b0, 10'h012, 9'h022, 1'b0);
      push_cmd(3'd5, 1'b0, 10'h013, 9'h023, 1'b0);
      idle(3);
      vblank = 1'b1;
      idle(12);

      // backpressure: fifth command waits for a one-cycle blanking pulse
      vblank = 1'b0;
      for (int i = 0; i < 4; i++) push_cmd(3'(i), 1'b0, 10'(i * 3), 9'(i * 5), 1'b0);
      cmd_valid = 1'b1; cmd_idx = 3'd6; cmd_att = 1'b0; cmd_x = 10'h3FF; cmd_y = 9'h1FF;
      tick(); tick();
      vblank = 1'b1; tick();
      vblank = 1'b0;
      push_cmd(3'd6, 1'b0, 10'h3FF, 9'h1FF, 1'b0);
      idle(4);
      vblank = 1'b1;
      idle(16);

      // blanking ends during the first of two strobes
      vblank = 1'b0;
      push_cmd(3'd3, 1'b0, 10'h100, 9'h080, 1'b0);
      push_cmd(3'd0, 1'b1, 10'h001, 9'h001, 1'b1);
      vblank = 1'b1; idle(1);
      vblank = 1'b0; idle(8);
      vblank = 1'b1; idle(6);

      // attribute load to the top index (out of range on the 6-sprite twin)
      push_cmd(3'd7, 1'b1, 10'h001, 9'h000, 1'b1);
      idle(5);
      push_cmd(3'd1, 1'b1, 10'h000, 9'h001, 1'b0);
      idle(5);

      // reset in the middle of a burst
      vblank = 1'b0;
      push_cmd(3'd2, 1'b0, 10'h0AA, 9'h055, 1'b1);
      push_cmd(3'd3, 1'b1, 10'h001, 9'h000, 1'b1);
      push_cmd(3'd4, 1'b0, 10'h0BB, 9'h066, 1'b0);
      vblank = 1'b1; idle(1);
      rst = 1'b1; idle(2);
      rst = 1'b0; idle(3);

      // randomised traffic with wandering blanking and rare resets
      for (int n = 0; n < 1500; n++) begin
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_idx   = 3'($urandom_range(0, 7));
         cmd_att   = 1'($urandom_range(0, 1));
         cmd_x     = 10'($urandom);
         cmd_y     = 9'($urandom);
         cmd_vis   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) vblank = ~vblank;
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;

      vblank = 1'b1;
      idle(30);
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
